// File: rtl/toggle_handshake_rx.sv
// Responder end of a two-phase (toggle) request/acknowledge link.
// The request toggle is synchronised, the data word is captured and offered
// on a valid/ready interface, and the acknowledge toggle is returned once the
// local consumer takes the word. Completed transfers are counted, and
// re-toggles of the request while a word is pending set a sticky error.
// SYNC_STAGES must be in the range 2..4.
module toggle_handshake_rx #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_t,
  input  logic [DW-1:0] data_in,
  input  logic          clr_err,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          ack_t,
  output logic [CW-1:0] evt_count,
  output logic          err
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_s;
  logic                   req_s_d;
  logic                   req_last;
  logic                   new_req;
  logic                   consume;
  logic                   viol;

  assign req_s = sync[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous request toggle, plus a one-cycle
  // delayed copy used to spot toggles while a word is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      req_s_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], req_t};
      req_s_d <= req_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle event decode; dout_ready is ignored in IDLE.
  always_comb begin
    state_nx = state;
    new_req  = 1'b0;
    consume  = 1'b0;
    viol     = 1'b0;
    case (state)
      IDLE: begin
        if (req_s != req_last) begin
          new_req  = 1'b1;
          state_nx = VALID;
        end
      end
      VALID: begin
        viol = (req_s != req_s_d);
        if (dout_ready) begin
          consume  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture, consume/acknowledge and transfer counting; dout keeps its last
  // value after consumption.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ack_t      <= 1'b0;
      req_last   <= 1'b0;
      evt_count  <= '0;
    end else begin
      if (new_req) begin
        dout       <= data_in;
        dout_valid <= 1'b1;
      end
      if (consume) begin
        dout_valid <= 1'b0;
        ack_t      <= ~ack_t;
        req_last   <= req_s;
        evt_count  <= evt_count + CW'(1);
      end
    end
  end

  // Sticky protocol-violation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (viol) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: a transmitter model drives toggle
// requests, expected words go through a scoreboard queue, and ack/count
// are tracked by a small reference model.
module tb_toggle_handshake_rx;

  localparam int DW  = 8;
  localparam int SS  = 2;
  localparam int CW  = 8;
  localparam int LAT = SS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_t;
  logic [DW-1:0] data_in;
  logic          clr_err;
  logic          dout_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          ack_t;
  logic [CW-1:0] evt_count;
  logic          err;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] sb[$];
  logic          ack_e;
  logic [CW-1:0] cnt_e;
  logic [DW-1:0] cur;

  toggle_handshake_rx #(.DW(DW), .SYNC_STAGES(SS), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_t      (req_t),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ack_t      (ack_t),
    .evt_count  (evt_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset of DUT and transmitter model; outputs checked before any edge.
  task automatic apply_reset();
    rst        = 1'b0;
    req_t      = 1'b0;
    dout_ready = 1'b0;
    clr_err    = 1'b0;
    data_in    = '0;
    #1;
    check("rst_dout",  32'(dout),       32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_ack",   32'(ack_t),      32'h0);
    check("rst_cnt",   32'(evt_count),  32'h0);
    check("rst_err",   32'(err),        32'h0);
    sb.delete();
    ack_e = 1'b0;
    cnt_e = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Toggle the request with a new word and wait (bounded) for it to appear.
  task automatic start(input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    data_in    = d;
    req_t      = ~req_t;
    dout_ready = 1'b0;
    sb.push_back(d);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dout_valid && n < 20);
    check("latency", 32'(n), 32'(LAT));
    cur = (sb.size() > 0) ? sb.pop_front() : '0;
    check("dout", 32'(dout), 32'(cur));
  endtask

  // Raise ready for one edge and check the consume/acknowledge effects.
  task automatic finish();
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    ack_e = ~ack_e;
    cnt_e = cnt_e + CW'(1);
    check("done_valid", 32'(dout_valid), 32'h0);
    check("done_ack",   32'(ack_t),      32'(ack_e));
    check("done_cnt",   32'(evt_count),  32'(cnt_e));
    check("done_dout",  32'(dout),       32'(cur));
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic xfer(input logic [DW-1:0] d, input int hold);
    start(d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(dout_valid), 32'h1);
      check("hold_dout",  32'(dout),       32'(d));
      check("hold_ack",   32'(ack_t),      32'(ack_e));
    end
    finish();
  endtask

  initial begin
    rst = 1'b1;
    #2;
    apply_reset();

    // Single transfer, immediate ready.
    xfer(8'hA5, 0);
    check("single_ack", 32'(ack_t), 32'h1);

    // Backpressure for 10 cycles.
    xfer(8'h3C, 10);

    // Back-to-back words; ack model walks 1,0,1,0.
    for (int i = 1; i <= 4; i++) xfer(DW'(i), 0);
    check("b2b_ack", 32'(ack_t), 32'h0);
    check("b2b_err", 32'(err),   32'h0);

    // Even number of extra toggles while a word is pending.
    start(8'h77);
    @(negedge clk); req_t = ~req_t;
    repeat (4) @(posedge clk);
    #1;
    check("viol_err", 32'(err), 32'h1);
    @(negedge clk); req_t = ~req_t;
    repeat (4) @(posedge clk);
    #1;
    check("viol_valid", 32'(dout_valid), 32'h1);
    check("viol_dout",  32'(dout),       32'h77);
    finish();
    repeat (6) @(posedge clk);
    #1;
    check("no_extra", 32'(dout_valid), 32'h0);
    check("err_kept", 32'(err),        32'h1);

    // Clear pulse.
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk);
    #1;
    check("err_clr", 32'(err), 32'h0);
    @(negedge clk); clr_err = 1'b0;

    // Violation set coinciding with clear: set wins.
    start(8'h99);
    @(negedge clk); req_t = ~req_t;
    @(posedge clk);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("set_wins", 32'(err), 32'h1);
    @(negedge clk); clr_err = 1'b0;
    @(posedge clk);
    #1;
    check("err_sticky", 32'(err), 32'h1);
    finish();

    // Reset mid-run with valid word, count 5 and err set.
    #2;
    apply_reset();
    for (int i = 0; i < 5; i++) xfer(DW'(8'h10 + i), 0);
    start(8'h55);
    @(negedge clk); req_t = ~req_t;
    repeat (4) @(posedge clk);
    #1;
    check("pre_valid", 32'(dout_valid), 32'h1);
    check("pre_cnt",   32'(evt_count),  32'h5);
    check("pre_err",   32'(err),        32'h1);
    #2;
    apply_reset();

    // Counter wrap.
    for (int i = 0; i < 255; i++) xfer(DW'(i), 0);
    check("cnt_255", 32'(evt_count), 32'hFF);
    xfer(8'hEE, 0);
    check("wrap_cnt", 32'(evt_count), 32'h0);
    check("wrap_err", 32'(err),       32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
